// File: rtl/accel_dma_port_pkg.sv
// Shared definitions for the accelerator DMA port: default widths, transfer
// direction encodings and the burst FSM states.
package accel_dma_port_pkg;

  localparam int ADDR_W_DEF     = 19;
  localparam int DATA_W_DEF     = 19;
  localparam int LEN_W_DEF      = 10;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/accel_dma_port_if.sv
// RAM request bus plus read/write streams between the DMA port, the arbiter
// and the accelerator core. master = DMA port side.
interface accel_dma_port_if
  import accel_dma_port_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_hp_active;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (
    output mem_valid, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_hp_active,
    output m_valid, m_data,
    input  m_ready,
    input  s_valid, s_data,
    output s_ready
  );

  modport slave (
    input  mem_valid, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_hp_active,
    input  m_valid, m_data,
    output m_ready,
    output s_valid, s_data,
    input  s_ready
  );

endinterface

// File: rtl/accel_dma_fifo.sv
// Small synchronous FIFO buffering read data between RAM grants and the
// accelerator stream. DEPTH must be a power of two, at least 2.
module accel_dma_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the reset pointers mark every entry invalid,
  // so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/accel_dma_port.sv
// Bus-master front end for one accelerator port: turns a start command into a
// linear burst of single-word RAM reads or writes, retrying while out-prioritised.
module accel_dma_port
  import accel_dma_port_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_dir,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  accel_dma_port_if.master  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;

  logic              more;
  logic              launch;
  logic              req_valid;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              grant;
  logic              m_valid_c;
  logic              s_ready_c;
  logic              busy_c;
  logic              done_c;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign more = (issued_q < len_q);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
    m_valid_c = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          launch = 1'b1;
          if (cfg_len == '0)          state_d = ST_DONE;
          else if (cfg_dir == DIR_WR) state_d = ST_WR;
          else                        state_d = ST_RD;
        end
      end
      ST_RD: begin
        busy_c    = 1'b1;
        req_valid = more & ~fifo_full;
        m_valid_c = ~fifo_empty;
        if (!more && fifo_empty) state_d = ST_DONE;
      end
      ST_WR: begin
        busy_c    = 1'b1;
        req_valid = bus.s_valid & more;
        req_write = 1'b1;
        req_wdata = bus.s_data;
        if (!more) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A cycle owned by a higher-priority requester is simply retried.
    grant     = req_valid & ~bus.mem_hp_active;
    s_ready_c = (state_q == ST_WR) & grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
    end else if (launch) begin
      addr_q   <= cfg_addr;
      len_q    <= cfg_len;
      issued_q <= '0;
    end else if (grant) begin
      addr_q   <= addr_q + ADDR_W'(1);
      issued_q <= issued_q + LEN_W'(1);
    end
  end

  assign fifo_push = grant & (state_q == ST_RD);
  assign fifo_pop  = m_valid_c & bus.m_ready;

  accel_dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (bus.mem_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.mem_valid = req_valid;
  assign bus.mem_write = req_write;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = req_wdata;
  assign bus.m_valid   = m_valid_c;
  assign bus.m_data    = fifo_rdata;
  assign bus.s_ready   = s_ready_c;
  assign busy          = busy_c;
  assign done          = done_c;

endmodule

// File: tb/tb_accel_dma_port.sv
// Directed bench for accel_dma_port: RAM read pattern model, hp contention,
// back-pressure, wrapping gapped writes, zero-length, ignored start, async reset.
module tb_accel_dma_port;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 19;
  localparam int LEN_W      = 10;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              cfg_dir;
  logic [ADDR_W-1:0] cfg_addr;
  logic [LEN_W-1:0]  cfg_len;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_bad    = 0;

  logic [DATA_W-1:0] ram_w [logic [ADDR_W-1:0]];

  accel_dma_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  accel_dma_port #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_dir  (cfg_dir),
    .cfg_addr (cfg_addr),
    .cfg_len  (cfg_len),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read contents are a fixed function of the address.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(a * 19'd7 + 19'h01234);
  endfunction

  always_comb bus.mem_rdata = pat(bus.mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_mval"},  bus.mem_valid, 0);
    check({tag, "_mwr"},   bus.mem_write, 0);
    check({tag, "_maddr"}, bus.mem_addr, 0);
    check({tag, "_wdat"},  bus.mem_wdata, 0);
    check({tag, "_m_val"}, bus.m_valid, 0);
    check({tag, "_s_rdy"}, bus.s_ready, 0);
  endtask

  // One complete burst. hp_mask bit k denies the k-th request cycle;
  // m_ready stays low for the first mready_delay cycles; restart_at pulses
  // a second start mid-burst (-1 = never).
  task automatic run_burst(input bit dir, input logic [ADDR_W-1:0] addr, input int len,
                           input logic [31:0] hp_mask, input int mready_delay,
                           input bit gapped, input int exp_req, input int restart_at);
    int cyc, req, grants, dones, wr_idx;
    bit fin, grant;
    logic [ADDR_W-1:0] exp_a;
    logic [DATA_W-1:0] q[$];
    cyc = 0; req = 0; grants = 0; dones = 0; wr_idx = 0; fin = 0;
    exp_a = addr;
    @(negedge clk);
    cfg_dir  = dir;
    cfg_addr = addr;
    cfg_len  = LEN_W'(len);
    start    = 1'b1;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    bus.mem_hp_active = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 300) begin
      start = (cyc == restart_at);
      if (start) cfg_addr = addr + 19'h100;
      bus.m_ready = (cyc >= mready_delay);
      bus.s_valid = dir && (wr_idx < len) && (!gapped || (cyc % 3 != 1));
      bus.s_data  = DATA_W'(wr_idx + 1);
      bus.mem_hp_active = 1'b0;
      #1;
      if (bus.mem_valid && req < 32) bus.mem_hp_active = hp_mask[req];
      #1;
      grant = bus.mem_valid && !bus.mem_hp_active;
      if (cyc == 0) check("busy_rise", busy, (len != 0));
      if (mready_delay > 0 && cyc == mready_delay) begin
        check("stall_grants", grants, FIFO_DEPTH);
        check("stall_req", bus.mem_valid, 0);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) check("rd_extra_word", bus.m_data, 32'hFFFF_FFFF);
        else               check("rd_data", bus.m_data, q.pop_front());
      end
      if (dir) begin
        check("s_ready_grant", bus.s_ready, grant);
        check("m_valid_in_wr", bus.m_valid, 0);
      end else begin
        check("s_ready_in_rd", bus.s_ready, 0);
      end
      if (grant) begin
        check("req_addr", bus.mem_addr, exp_a);
        check("req_write", bus.mem_write, dir);
        if (dir) begin
          check("req_wdata", bus.mem_wdata, bus.s_data);
          ram_w[bus.mem_addr] = bus.mem_wdata;
          wr_idx++;
        end else begin
          q.push_back(pat(exp_a));
        end
        exp_a = exp_a + 19'd1;
        grants++;
      end
      if (bus.mem_valid) req++;
      if (done) begin
        dones++;
        check("busy_fall", busy, 0);
        fin = 1;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.mem_hp_active = 1'b0;
    check("done_count", dones, 1);
    check("grant_count", grants, len);
    check("req_cycles", req, exp_req);
    check("rd_undelivered", q.size(), 0);
    @(negedge clk);
    #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_req", bus.mem_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_dir = 1'b0;
    cfg_addr = '0;
    cfg_len = '0;
    bus.mem_hp_active = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: plain read of 8 words
    run_burst(1'b0, 19'h00010, 8, 32'h0, 0, 1'b0, 8, -1);
    // 2: same read, request cycles 2 and 3 lost to a higher-priority master
    run_burst(1'b0, 19'h00010, 8, 32'h0000_000C, 0, 1'b0, 10, -1);
    // 3: consumer stalled, FIFO fills then drains in order
    run_burst(1'b0, 19'h00010, 8, 32'h0, 10, 1'b0, 8, -1);
    // 4: gapped write wrapping the top of the address space, one hp hit
    run_burst(1'b1, 19'h7FFFE, 4, 32'h0000_0002, 0, 1'b1, 5, -1);
    check("ram_7fffe", ram_w[19'h7FFFE], 1);
    check("ram_7ffff", ram_w[19'h7FFFF], 2);
    check("ram_00000", ram_w[19'h00000], 3);
    check("ram_00001", ram_w[19'h00001], 4);
    // 5: zero-length burst, then a read with a start pulse while busy
    run_burst(1'b0, 19'h00050, 0, 32'h0, 0, 1'b0, 0, -1);
    run_burst(1'b0, 19'h00020, 6, 32'h0, 0, 1'b0, 6, 2);

    // 6: async reset with three words buffered
    @(negedge clk);
    cfg_dir = 1'b0; cfg_addr = 19'h00040; cfg_len = 10'd8; start = 1'b1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_m_valid", bus.m_valid, 1);
    check("pre_rst_addr", bus.mem_addr, 19'h00043);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk);
    check("rst_hold_done", done, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_done", done, 0);
    check("post_rst_m_valid", bus.m_valid, 0);
    run_burst(1'b0, 19'h00080, 5, 32'h0, 0, 1'b0, 5, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
